// File: rtl/spi_byte_rx.sv
`timescale 1ns/1ps
// spi_byte_rx: SPI mode-0 slave byte deserializer.
// Synchronizes SCLK/MOSI/CS_N/DC into clk_in, assembles 8-bit words and
// emits a one-cycle byte_rdy_out with byte_data_out/dc_out aligned to it.
// Optional feature macro: SPI_BYTE_RX_FRAME_ERR_EN (adds frame_err_out).
// Ports:
//   clk_in, rst_n_in        system clock (>= 4x SCLK), async active-low reset
//   spi_sclk_in/mosi/cs_n   raw SPI lines, async to clk_in
//   dc_in                   raw data/command line (1 = data)
//   spi_cs_n_out            synchronized CS_N
//   byte_rdy_out            one-clk pulse, new byte valid
//   byte_data_out, dc_out   last complete byte and its DC, held
//   frame_err_out           pulse when CS rises mid-byte (macro only)
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2,  // legal range 2..4
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  input  logic       spi_cs_n_in,
  input  logic       dc_in,
  output logic       spi_cs_n_out,
  output logic       byte_rdy_out,
  output logic [7:0] byte_data_out,
  output logic       dc_out
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
  ,
  output logic       frame_err_out
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchronizer chains; vld_sr tracks when the cs chain holds real samples.
  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] dc_sr;
  logic [SYNC_STAGES-1:0] vld_sr;

  logic sync_sclk;
  logic sync_mosi;
  logic sync_cs;
  logic sync_dc;
  logic sync_vld;

  logic sclk_d;
  logic cs_d;
  logic armed;

  logic sclk_rise;
  logic cs_fall;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] shift_nxt;
  logic [BYTE_W-1:0] shifted;
  logic              rdy_nxt;
  logic [BYTE_W-1:0] data_nxt;
  logic              dc_nxt;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
  logic              err_nxt;
`endif

  // Identical chains for all four inputs keep their relative timing.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '1;
      dc_sr   <= '0;
      vld_sr  <= '0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk_in};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi_in};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n_in};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], dc_in};
      vld_sr  <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_sclk    = sclk_sr[SYNC_STAGES-1];
  assign sync_mosi    = mosi_sr[SYNC_STAGES-1];
  assign sync_cs      = cs_sr[SYNC_STAGES-1];
  assign sync_dc      = dc_sr[SYNC_STAGES-1];
  assign sync_vld     = vld_sr[SYNC_STAGES-1];
  assign spi_cs_n_out = sync_cs;

  // Edge-detect flops. armed only sets once a genuinely sampled CS high has
  // reached the end of the chain, so a CS already low at reset release
  // (seen as a fall from the reset value of 1) cannot open a window.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sclk_d <= sync_sclk;
      cs_d   <= sync_cs;
      armed  <= armed | (sync_vld & sync_cs);
    end
  end

  assign sclk_rise = sync_sclk & ~sclk_d;
  assign cs_fall   = armed & cs_d & ~sync_cs;

  // Bit-order selection for the incoming sample.
  assign shifted = (MSB_FIRST != 0) ? {shift_q[BYTE_W-2:0], sync_mosi}
                                    : {sync_mosi, shift_q[BYTE_W-1:1]};

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    rdy_nxt     = 1'b0;
    data_nxt    = byte_data_out;
    dc_nxt      = dc_out;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
    err_nxt     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        bit_cnt_nxt = '0;
        if (cs_fall) begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // CS high wins over a coincident SCLK edge.
        if (sync_cs) begin
          state_nxt   = ST_IDLE;
          bit_cnt_nxt = '0;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
          err_nxt     = (bit_cnt != '0);
`endif
        end else if (sclk_rise) begin
          shift_nxt   = shifted;
          bit_cnt_nxt = CNT_W'(bit_cnt + CNT_W'(1));
          if (bit_cnt == CNT_W'(7)) begin
            rdy_nxt  = 1'b1;
            data_nxt = shifted;
            dc_nxt   = sync_dc;
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt       <= '0;
      shift_q       <= '0;
      byte_rdy_out  <= 1'b0;
      byte_data_out <= '0;
      dc_out        <= 1'b0;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
      frame_err_out <= 1'b0;
`endif
    end else begin
      bit_cnt       <= bit_cnt_nxt;
      shift_q       <= shift_nxt;
      byte_rdy_out  <= rdy_nxt;
      byte_data_out <= data_nxt;
      dc_out        <= dc_nxt;
`ifdef SPI_BYTE_RX_FRAME_ERR_EN
      frame_err_out <= err_nxt;
`endif
    end
  end

endmodule
